// File: rtl/fetch_unit.sv
// Instruction-fetch and PC-sequencing stage for the 16-bit single-cycle core.
// Fetches one instruction at a time from a variable-latency memory, holds it
// for the datapath until acknowledged, then picks the next PC (sequential,
// conditional PC-relative branch, conditional register branch) or halts.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ack,
  input  logic [2:0]  flags,
  input  logic [15:0] br_reg_data,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        halted
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    ISSUE  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;

  logic [3:0]  opcode;
  logic [2:0]  cond;
  logic        flag_z, flag_v, flag_n;
  logic        cond_true;
  logic [15:0] branch_offset;
  logic [15:0] b_target;
  logic [15:0] br_target;

  assign opcode        = instr_q[15:12];
  assign cond          = instr_q[11:9];
  assign flag_z        = flags[2];
  assign flag_v        = flags[1];
  assign flag_n        = flags[0];
  assign pc_plus2      = pc_q + 16'd2;
  assign branch_offset = {{6{instr_q[8]}}, instr_q[8:0], 1'b0};
  assign b_target      = pc_plus2 + branch_offset;
  assign br_target     = br_reg_data & 16'hFFFE;

  // Evaluate the branch condition field against the live flags.
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'b000:  cond_true = ~flag_z;
      3'b001:  cond_true = flag_z;
      3'b010:  cond_true = ~flag_z & ~flag_n;
      3'b011:  cond_true = flag_n;
      3'b100:  cond_true = flag_z | (~flag_z & ~flag_n);
      3'b101:  cond_true = flag_n | flag_z;
      3'b110:  cond_true = flag_v;
      default: cond_true = 1'b1;
    endcase
  end

  // Next-state, next-PC and instruction-latch logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem_rdy) begin
          instr_d = imem_data;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ack) begin
          state_d = FETCH;
          case (opcode)
            OP_HLT: begin
              state_d = HALTED;
            end
            OP_B: begin
              pc_d = cond_true ? b_target : pc_plus2;
            end
            OP_BR: begin
              pc_d = cond_true ? br_target : pc_plus2;
            end
            default: begin
              pc_d = pc_plus2;
            end
          endcase
        end
      end
      default: begin
        state_d = HALTED;
      end
    endcase
  end

  // State, PC and instruction registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == ISSUE);
  assign pc          = pc_q;
  assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the stimulus process plays instruction
// memory and datapath, predicts fetch addresses / issued instructions / halts
// with an arithmetic PC model, and a negedge monitor pops and compares.
module tb_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ack;
  logic [2:0]  flags;
  logic [15:0] br_reg_data;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        halted;

  int checks = 0;
  int passes = 0;

  logic [15:0] fetch_q[$];
  logic [31:0] issue_q[$];
  logic [15:0] halt_q[$];
  logic [15:0] model_pc;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdy   (imem_rdy),
    .imem_data  (imem_data),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ack  (instr_ack),
    .flags      (flags),
    .br_reg_data(br_reg_data),
    .pc         (pc),
    .pc_plus2   (pc_plus2),
    .halted     (halted)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the design wedges somewhere unforeseen.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Reference: next PC from the architectural branch rules, in plain integers.
  function automatic logic [15:0] modelNextPc(input logic [15:0] cur, input logic [15:0] ins,
                                              input logic [2:0] fl, input logic [15:0] rs);
    bit z, v, n, take;
    int off, target;
    z = fl[2]; v = fl[1]; n = fl[0];
    case (int'(ins[11:9]))
      0: take = !z;
      1: take = z;
      2: take = !z && !n;
      3: take = n;
      4: take = z || (!z && !n);
      5: take = n || z;
      6: take = v;
      default: take = 1;
    endcase
    target = (int'(cur) + 2) % 65536;
    if (ins[15:12] == 4'hC && take) begin
      off = int'(ins[8:0]);
      if (off > 255) off = off - 512;
      target = (int'(cur) + 2 + 2 * off + 131072) % 65536;
    end else if (ins[15:12] == 4'hD && take) begin
      target = int'(rs) - (int'(rs) % 2);
    end
    return 16'(target);
  endfunction

  // Play memory and datapath for one instruction; predictions go to the queues.
  task automatic applyStimulus(input logic [15:0] ins, input int lat, input int ack_dly,
                               input logic [2:0] fl, input logic [15:0] rs);
    int n;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      checks++;
      $display("[TB] FAIL fetch_timeout: got imem_req=0 for 20 cycles, required imem_req=1");
      return;
    end
    repeat (lat) begin
      imem_rdy  = 1'b0;
      instr_ack = 1'($urandom_range(1, 0));
      @(negedge clk);
    end
    instr_ack = 1'b0;
    imem_rdy  = 1'b1;
    imem_data = ins;
    issue_q.push_back({ins, model_pc});
    @(negedge clk);
    imem_rdy  = 1'b0;
    imem_data = 16'($urandom);
    repeat (ack_dly) begin
      imem_rdy = 1'($urandom_range(1, 0));
      flags    = 3'($urandom);
      @(negedge clk);
    end
    imem_rdy    = 1'b0;
    flags       = fl;
    br_reg_data = rs;
    instr_ack   = 1'b1;
    if (ins[15:12] == 4'hF) begin
      halt_q.push_back(model_pc);
    end else begin
      model_pc = modelNextPc(model_pc, ins, fl, rs);
      fetch_q.push_back(model_pc);
    end
    @(negedge clk);
    instr_ack   = 1'b0;
    flags       = 3'($urandom);
    br_reg_data = 16'($urandom);
  endtask

  // Monitor: compares every DUT presentation against the scoreboard queues.
  logic        prev_req = 1'b0, prev_valid = 1'b0, prev_halted = 1'b0;
  logic [15:0] cur_fetch, cur_instr, cur_pc, cur_halt_pc;
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("reset_req", {15'd0, imem_req}, 16'd0);
      checkOutput("reset_valid", {15'd0, instr_valid}, 16'd0);
      checkOutput("reset_halted", {15'd0, halted}, 16'd0);
      checkOutput("reset_pc", pc, RESET_PC);
      checkOutput("reset_instr", instr, 16'h0000);
      prev_req = 1'b0; prev_valid = 1'b0; prev_halted = 1'b0;
    end else begin
      checkOutput("addr_eq_pc", imem_addr, pc);
      checkOutput("pc_plus2", pc_plus2, 16'((int'(pc) + 2) % 65536));
      checkOutput("req_valid_excl", {15'd0, imem_req & instr_valid}, 16'd0);
      if (imem_req && !prev_req) begin
        if (fetch_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_fetch: got fetch at %h, required no fetch", imem_addr);
        end else begin
          cur_fetch = fetch_q.pop_front();
          checkOutput("fetch_addr", imem_addr, cur_fetch);
        end
      end else if (imem_req) begin
        checkOutput("fetch_addr_stable", imem_addr, cur_fetch);
      end
      if (instr_valid && !prev_valid) begin
        if (issue_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_issue: got instr %h, required no issue", instr);
        end else begin
          {cur_instr, cur_pc} = issue_q.pop_front();
          checkOutput("issue_instr", instr, cur_instr);
          checkOutput("issue_pc", pc, cur_pc);
        end
      end else if (instr_valid) begin
        checkOutput("issue_instr_stable", instr, cur_instr);
        checkOutput("issue_pc_stable", pc, cur_pc);
      end
      if (halted && !prev_halted) begin
        if (halt_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_halt: got halted at pc %h, required running", pc);
        end else begin
          cur_halt_pc = halt_q.pop_front();
        end
      end
      if (halted) begin
        checkOutput("halt_pc", pc, cur_halt_pc);
        checkOutput("halt_req", {15'd0, imem_req}, 16'd0);
        checkOutput("halt_valid", {15'd0, instr_valid}, 16'd0);
      end
      prev_req = imem_req; prev_valid = instr_valid; prev_halted = halted;
    end
  end

  // Abort a pending fetch with reset, poke rdy while in reset/BOOT, restart.
  task automatic resetMidFetch();
    int n;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    fetch_q.delete(); issue_q.delete(); halt_q.delete();
    #1;
    checkOutput("req_drops_with_rst", {15'd0, imem_req}, 16'd0);
    imem_rdy  = 1'b1;
    imem_data = 16'hBEEF;
    repeat (2) @(negedge clk);
    model_pc = RESET_PC;
    fetch_q.push_back(RESET_PC);
    rst = 1'b0;
    @(negedge clk);
    imem_rdy = 1'b0;
  endtask

  // Main sequence: directed cases, randomized run, reset abort, halt.
  initial begin
    logic [15:0] ins;
    int r;
    rst = 1'b1; imem_rdy = 1'b0; imem_data = 16'h0; instr_ack = 1'b0;
    flags = 3'b0; br_reg_data = 16'h0;
    model_pc = RESET_PC;
    fetch_q.push_back(RESET_PC);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    applyStimulus(16'h0123, 3, 0, 3'b000, 16'h0000);
    applyStimulus(16'hDE50, 0, 1, 3'b000, 16'h0011);
    applyStimulus(16'hC3FE, 1, 0, 3'b100, 16'h0000);
    applyStimulus(16'hDE50, 0, 0, 3'b000, 16'h0010);
    applyStimulus(16'hC3FE, 2, 2, 3'b000, 16'h0000);
    applyStimulus(16'hDE50, 0, 0, 3'b000, 16'h1235);
    applyStimulus(16'hD650, 1, 1, 3'b100, 16'h4444);
    applyStimulus(16'hDE50, 0, 0, 3'b000, 16'hFFFF);
    applyStimulus(16'h0123, 0, 0, 3'b000, 16'h0000);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(9, 0);
      if (r < 4)      ins = {4'hC, 12'($urandom)};
      else if (r < 7) ins = {4'hD, 12'($urandom)};
      else            ins = {4'($urandom_range(14, 0)), 12'($urandom)};
      applyStimulus(ins, $urandom_range(3, 0), $urandom_range(2, 0),
                    3'($urandom), 16'($urandom));
    end

    resetMidFetch();
    applyStimulus(16'h0123, 1, 0, 3'b000, 16'h0000);
    applyStimulus(16'hDE50, 0, 0, 3'b000, 16'h0040);
    applyStimulus(16'hF000, 2, 1, 3'b111, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      imem_rdy  = 1'($urandom_range(1, 0));
      imem_data = 16'($urandom);
      instr_ack = 1'($urandom_range(1, 0));
      @(negedge clk);
    end
    imem_rdy = 1'b0; instr_ack = 1'b0;
    @(negedge clk);

    checkOutput("halt_observed", 16'(halt_q.size()), 16'd0);
    checkOutput("fetch_q_drained", 16'(fetch_q.size()), 16'd0);
    checkOutput("issue_q_drained", 16'(issue_q.size()), 16'd0);
    checkOutput("final_halted", {15'd0, halted}, 16'd1);
    checkOutput("final_pc", pc, 16'h0040);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
